dm_split_access_ctrl: RTL and testbench
=======================================

DM_SPLIT_ACCESS_CTRL -- requirements
Module: dm_split_access_ctrl

Interface
REQ-001 ADDR_W, 32, byte-address width; DM lines are fixed at 8 bytes (64 bits).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_req_valid  in  1  access request present.
REQ-005 o_req_ready  out  1  request accepted on a clk edge where valid && ready.
REQ-006 i_req_wr  in  1  1 = store, 0 = load.
REQ-007 i_req_addr  in  ADDR_W  byte address, any alignment.
REQ-008 i_req_unit  in  2  access size, mem_unit_t (B/HW/W/DW).
REQ-009 i_req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
REQ-010 i_req_wdata  in  64  store data, right-justified.
REQ-011 o_dm_en  out  1  DM access strobe.
REQ-012 o_dm_wr  out  1  DM write when o_dm_en is high.
REQ-013 o_dm_addr  out  ADDR_W  line address, bits [2:0] always 0.
REQ-014 o_dm_be  out  8  byte-lane write enables.
REQ-015 o_dm_wdata  out  64  lane-aligned write data.
REQ-016 i_dm_rdata  in  64  line read data, valid the cycle after a read strobe.
REQ-017 o_rsp_valid  out  1  one-cycle completion pulse.
REQ-018 o_rsp_rdata  out  64  load result, qualified by o_rsp_valid; 0 for stores.
REQ-019 o_busy  out  1  state != IDLE; feeds the pipeline staller.

Function
REQ-020 FSM states are IDLE, LO, HI and DONE; o_req_ready is (state == IDLE).
REQ-021 Accept in IDLE:
- register wr, addr, unit, unsigned and wdata;
- go to LO.
REQ-022 Size and crossing:
- n = 1/2/4/8 bytes for B/HW/W/DW;
- off = addr[2:0];
- cross = (off + n > 8), evaluated 4 bits wide.
REQ-023 Lane vectors:
- be16 = ((1<<n)-1) << off, 16 bits;
- wd128 = (wdata masked to n bytes) << (8*off), 128 bits;
- bytes outside be16 are 0.
REQ-024 LO state:
- o_dm_en = 1;
- o_dm_addr = {addr[ADDR_W-1:3], 3'b000};
- o_dm_be = be16[7:0], o_dm_wdata = wd128[63:0];
- go to HI if cross, else DONE.
REQ-025 HI state:
- o_dm_en = 1;
- o_dm_addr = LO line + 8, modulo 2^ADDR_W (top line wraps to 0);
- o_dm_be = be16[15:8], o_dm_wdata = wd128[127:64];
- register i_dm_rdata (the LO read data) into lo_line;
- go to DONE.
REQ-026 o_dm_wr equals the captured wr in LO/HI; all DM outputs are 0 whenever o_dm_en = 0.
REQ-027 DONE state:
- o_rsp_valid = 1, o_dm_en = 0;
- unconditional transition to IDLE;
- no accept in DONE.
REQ-028 Load result in DONE:
- r128 = cross ? {i_dm_rdata, lo_line} : {64'b0, i_dm_rdata};
- keep the low n bytes of r128 >> (8*off);
- sign-extend from bit 8n-1 unless unsigned or DW.
REQ-029 Latency from accept edge T:
- LO strobe in cycle T+1;
- o_rsp_valid in cycle T+2 (non-crossing) or T+3 (crossing);
- o_req_ready high in the following cycle.
REQ-030 Crossing cases:
- B never crosses;
- HW crosses only at off = 7;
- W crosses at off 5..7;
- DW crosses at off 1..7.
REQ-031 i_req_valid while not ready is ignored; the requester holds the request stable until accepted.
REQ-032 i_dm_rdata is ignored for stores and outside HI/DONE.

Reset
REQ-033 rst_n low asynchronously forces IDLE and clears all captured registers and lo_line.
REQ-034 While rst_n is low: DM outputs, o_rsp_valid, o_rsp_rdata and o_busy are 0, o_req_ready is 1, and no request is accepted.
REQ-035 Reset in LO or HI aborts the access without a response; a crossing store may have written only its low part, and this block does not recover it.

Structure
REQ-036 The shared package holds mem_unit_t (B=0, HW=1, W=2, DW=3), matching the existing size defines; the FSM state enum stays local.
REQ-037 One combinational sub-module, dm_lane_align, computes be16, wd128 and the load extract/extend; it is instantiated once.

Verification
REQ-038 Store W @0x104, data 0xDEADBEEF -> one strobe: addr 0x100, be 0xF0, wdata 0xDEADBEEF00000000; rsp at T+2.
REQ-039 Store DW @0x10B, data 0x1122334455667788:
- LO: addr 0x108, be 0xF8, wdata 0x4455667788000000;
- HI: addr 0x110, be 0x07, wdata 0x0000000000112233;
- rsp at T+3.
REQ-040 Load HW signed @0x207, LO line byte7 = 0x80, HI line byte0 = 0xFF -> rdata 0xFFFFFFFFFFFFFF80; the same load unsigned -> 0x000000000000FF80.
REQ-041 Store W @0xFFFFFFFE -> LO addr 0xFFFFFFF8, be 0xC0; HI addr 0x00000000, be 0x03.
REQ-042 Reset pulsed during HI of a crossing store:
- DM outputs drop to 0 immediately;
- no o_rsp_valid;
- the next request is accepted normally after release.
REQ-043 Second request held valid throughout a busy access -> accepted exactly on the edge ending the first cycle after DONE.

Source files
------------

// File: rtl/dm_split_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dm_split_access_ctrl_pkg
// Shared types and constants for the data-memory split access controller.
//   mem_unit_t  : access size encoding, matches the existing B/HW/W/DW defines
//   unit_bytes  : byte count (1/2/4/8) of an access size, 4 bits wide
// -----------------------------------------------------------------------------
package dm_split_access_ctrl_pkg;

  localparam int DM_ADDR_W     = 32;
  localparam int DM_LINE_BYTES = 8;

  typedef enum logic [1:0] {
    MEM_B  = 2'd0,
    MEM_HW = 2'd1,
    MEM_W  = 2'd2,
    MEM_DW = 2'd3
  } mem_unit_t;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] unit_bytes(input mem_unit_t unit);
    logic [3:0] n;
    case (unit)
      MEM_B:   n = 4'd1;
      MEM_HW:  n = 4'd2;
      MEM_W:   n = 4'd4;
      MEM_DW:  n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dm_split_access_ctrl_lane_align.sv
// -----------------------------------------------------------------------------
// dm_lane_align
// Purely combinational lane steering for one (possibly line-crossing) access.
// The access is viewed as a 16-byte window made of the addressed line (low
// half) and the following line (high half).
//   i_unit     : access size
//   i_off      : byte offset of the access inside its first line
//   i_unsigned : zero-extend loads when 1, sign-extend when 0
//   i_wdata    : right-justified store data
//   i_rdata128 : {second line, first line} read data for the load extract
//   o_cross    : access spills into the next line
//   o_be16     : byte enables across the 16-byte window
//   o_wd128    : store data placed on its lanes, zero outside o_be16
//   o_rdata    : extracted and extended load result
// -----------------------------------------------------------------------------
module dm_lane_align
  import dm_split_access_ctrl_pkg::*;
(
  input  mem_unit_t     i_unit,
  input  logic [2:0]    i_off,
  input  logic          i_unsigned,
  input  logic [63:0]   i_wdata,
  input  logic [127:0]  i_rdata128,
  output logic          o_cross,
  output logic [15:0]   o_be16,
  output logic [127:0]  o_wd128,
  output logic [63:0]   o_rdata
);

  logic [3:0]  w_n;
  logic [63:0] w_byte_mask;
  logic [63:0] w_rshift;
  logic        w_sext;

  // Lane placement for stores and extract/extend for loads.
  always_comb begin
    w_n         = unit_bytes(i_unit);
    // 4-bit sum: off (max 7) + n (max 8) never overflows
    o_cross     = (({1'b0, i_off} + w_n) > 4'd8);
    o_be16      = ((16'd1 << w_n) - 16'd1) << i_off;
    w_byte_mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      w_byte_mask[8*i +: 8] = (4'(i) < w_n) ? 8'hFF : 8'h00;
    end
    o_wd128  = {64'd0, (i_wdata & w_byte_mask)} << {i_off, 3'b000};
    // Only the low 64 bits of the shifted window can hold the result
    w_rshift = 64'(i_rdata128 >> {i_off, 3'b000});
    w_sext   = ~i_unsigned;
    case (i_unit)
      MEM_B:   o_rdata = {{56{w_rshift[7]  & w_sext}}, w_rshift[7:0]};
      MEM_HW:  o_rdata = {{48{w_rshift[15] & w_sext}}, w_rshift[15:0]};
      MEM_W:   o_rdata = {{32{w_rshift[31] & w_sext}}, w_rshift[31:0]};
      MEM_DW:  o_rdata = w_rshift;
      default: o_rdata = 64'd0;
    endcase
  end

endmodule

// File: rtl/dm_split_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_split_access_ctrl
// Turns one byte-addressed load/store of 1..8 bytes into one or two aligned
// 8-byte data-memory line accesses, and assembles the load result.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_req_*          : request (valid/ready handshake, accepted in IDLE only)
//   o_dm_*           : line access strobe, address, byte enables, write data
//   i_dm_rdata       : line read data, valid the cycle after a read strobe
//   o_rsp_valid/rdata: one-cycle completion pulse with load result
//   o_busy           : controller not idle
// Sequence: IDLE -accept-> LO -> (HI if crossing) -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module dm_split_access_ctrl
  import dm_split_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_unit,
  input  logic              i_req_unsigned,
  input  logic [63:0]       i_req_wdata,
  output logic              o_dm_en,
  output logic              o_dm_wr,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [7:0]        o_dm_be,
  output logic [63:0]       o_dm_wdata,
  input  logic [63:0]       i_dm_rdata,
  output logic              o_rsp_valid,
  output logic [63:0]       o_rsp_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(DM_LINE_BYTES);

  state_t            r_state;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  mem_unit_t         r_unit;
  logic              r_unsigned;
  logic [63:0]       r_wdata;
  logic [63:0]       r_lo_line;

  logic              w_cross;
  logic [15:0]       w_be16;
  logic [127:0]      w_wd128;
  logic [127:0]      w_r128;
  logic [63:0]       w_load;
  logic [ADDR_W-1:0] w_lo_addr;

  assign w_lo_addr = {r_addr[ADDR_W-1:3], 3'b000};
  // In DONE the current read data is the last line read: HI when crossing
  assign w_r128    = w_cross ? {i_dm_rdata, r_lo_line} : {64'd0, i_dm_rdata};

  dm_lane_align u_lane_align (
    .i_unit     (r_unit),
    .i_off      (r_addr[2:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata128 (w_r128),
    .o_cross    (w_cross),
    .o_be16     (w_be16),
    .o_wd128    (w_wd128),
    .o_rdata    (w_load)
  );

  // Access sequencer and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_unit     <= MEM_B;
      r_unsigned <= 1'b0;
      r_wdata    <= 64'd0;
      r_lo_line  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_wr       <= i_req_wr;
            r_addr     <= i_req_addr;
            r_unit     <= mem_unit_t'(i_req_unit);
            r_unsigned <= i_req_unsigned;
            r_wdata    <= i_req_wdata;
            r_state    <= S_LO;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_LO: begin
          r_state <= w_cross ? S_HI : S_DONE;
        end
        S_HI: begin
          // Read data now belongs to the LO line; meaningless for stores
          if (!r_wr) begin
            r_lo_line <= i_dm_rdata;
          end else begin
            r_lo_line <= r_lo_line;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state and captured request.
  always_comb begin
    o_dm_en     = 1'b0;
    o_dm_wr     = 1'b0;
    o_dm_addr   = '0;
    o_dm_be     = 8'd0;
    o_dm_wdata  = 64'd0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = 64'd0;
    case (r_state)
      S_LO: begin
        o_dm_en    = 1'b1;
        o_dm_wr    = r_wr;
        o_dm_addr  = w_lo_addr;
        o_dm_be    = w_be16[7:0];
        o_dm_wdata = w_wd128[63:0];
      end
      S_HI: begin
        o_dm_en    = 1'b1;
        o_dm_wr    = r_wr;
        o_dm_addr  = w_lo_addr + LINE_STEP;  // wraps past the top line
        o_dm_be    = w_be16[15:8];
        o_dm_wdata = w_wd128[127:64];
      end
      S_DONE: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_wr ? 64'd0 : w_load;
      end
      default: begin
        o_dm_en = 1'b0;
      end
    endcase
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dm_split_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_split_access_ctrl
// Bench for dm_split_access_ctrl. A byte-addressed memory answers the DM
// strobes; a separate byte-level reference memory predicts load results and
// the expected line strobes of each access.
// -----------------------------------------------------------------------------
module tb_dm_split_access_ctrl;
  import dm_split_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid, o_req_ready, i_req_wr, i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [1:0]  i_req_unit;
  logic [63:0] i_req_wdata;
  logic        o_dm_en, o_dm_wr;
  logic [31:0] o_dm_addr;
  logic [7:0]  o_dm_be;
  logic [63:0] o_dm_wdata;
  logic [63:0] i_dm_rdata = 64'd0;
  logic        o_rsp_valid, o_busy;
  logic [63:0] o_rsp_rdata;

  always #5 clk = ~clk;

  dm_split_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_unit(i_req_unit), .i_req_unsigned(i_req_unsigned),
    .i_req_wdata(i_req_wdata), .o_dm_en(o_dm_en), .o_dm_wr(o_dm_wr),
    .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be), .o_dm_wdata(o_dm_wdata),
    .i_dm_rdata(i_dm_rdata), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_busy(o_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wd;
  } strobe_t;

  strobe_t     s_q[$];
  int          rsp_c_q[$];
  logic [63:0] rsp_d_q[$];
  logic [7:0]  dut_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [63:0] nxt_rdata = 64'd0;
  logic [63:0] mon_line;
  logic [31:0] mon_a;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h[31:24] ^ h[15:8];
  endfunction

  function automatic logic [7:0] dut_rd(input logic [31:0] a);
    if (dut_mem.exists(a)) return dut_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // Reference: bytes a .. a+n-1 (wrapping) take data bytes 0 .. n-1
  task automatic ref_store(input logic [31:0] a, input int n, input logic [63:0] d);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
  endtask

  function automatic logic [63:0] ref_load(input logic [31:0] a, input int n, input logic uns);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
    if (!uns && n < 8 && v[8*n-1]) begin
      for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // Reference: which aligned lines the touched bytes fall in, and their lanes
  task automatic model_strobes(input logic [31:0] a, input int n, input logic [63:0] d,
                               output int cnt, output logic [1:0][31:0] la,
                               output logic [1:0][7:0] be, output logic [1:0][63:0] wd);
    logic [31:0] ba;
    int s;
    la[0] = {a[31:3], 3'b000};
    la[1] = 32'd0;
    be = '0;
    wd = '0;
    cnt = 1;
    for (int k = 0; k < n; k++) begin
      ba = a + 32'(k);
      s = ({ba[31:3], 3'b000} == la[0]) ? 0 : 1;
      if (s == 1) begin
        cnt = 2;
        la[1] = {ba[31:3], 3'b000};
      end
      be[s][ba[2:0]] = 1'b1;
      wd[s][{ba[2:0], 3'b000} +: 8] = d[8*k +: 8];
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    i_dm_rdata <= nxt_rdata;
  end

  // Memory responder and monitor, sampled mid-cycle
  always @(negedge clk) begin
    nxt_rdata = {$urandom, $urandom};
    if (o_dm_en) begin
      s_q.push_back('{c: cyc, wr: o_dm_wr, addr: o_dm_addr, be: o_dm_be, wd: o_dm_wdata});
      for (int k = 0; k < 8; k++) begin
        mon_a = o_dm_addr + 32'(k);
        if (o_dm_wr && o_dm_be[k]) dut_mem[mon_a] = o_dm_wdata[8*k +: 8];
        mon_line[8*k +: 8] = dut_rd(mon_a);
      end
      if (!o_dm_wr) nxt_rdata = mon_line;
    end
    if (o_rsp_valid) begin
      rsp_c_q.push_back(cyc);
      rsp_d_q.push_back(o_rsp_rdata);
    end
  end

  task automatic clear_queues();
    s_q.delete();
    rsp_c_q.delete();
    rsp_d_q.delete();
  endtask

  // Issue one request, wait for its response (bounded), sample ready after it
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] unit,
                       input logic uns, input logic [63:0] wd,
                       output int acc, output bit ok, output logic rdy);
    acc = -1;
    ok = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    i_req_wr = wr; i_req_addr = addr; i_req_unit = unit;
    i_req_unsigned = uns; i_req_wdata = wd; i_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_req_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      i_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_wr = 1'($urandom); i_req_addr = $urandom; i_req_wdata = {$urandom, $urandom};
    clear_queues();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (rsp_c_q.size() > 0) break;
    end
    ok = (rsp_c_q.size() > 0);
    @(negedge clk);
    rdy = o_req_ready;
  endtask

  task automatic test_reset();
    i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 32'h0000_0104;
    i_req_unit = 2'd2; i_req_unsigned = 1'b0; i_req_wdata = 64'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", o_req_ready); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    vectors++; if ({o_dm_en, o_dm_wr, o_dm_be} !== 10'd0) begin miscompares++; $display("FAIL rst_dm_ctl: got en=%b wr=%b be=%h want 0", o_dm_en, o_dm_wr, o_dm_be); end
    vectors++; if ({o_dm_addr, o_dm_wdata} !== 96'd0) begin miscompares++; $display("FAIL rst_dm_data: got addr=%h wdata=%h want 0", o_dm_addr, o_dm_wdata); end
    vectors++; if ({o_rsp_valid, o_rsp_rdata} !== 65'd0) begin miscompares++; $display("FAIL rst_rsp: got v=%b d=%h want 0", o_rsp_valid, o_rsp_rdata); end
    i_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (o_busy !== 1'b0 || s_q.size() != 0) begin miscompares++; $display("FAIL rst_no_accept: got busy=%b strobes=%0d want 0/0", o_busy, s_q.size()); end
  endtask

  task automatic test_directed();
    int acc; bit ok; logic rdy;
    // Aligned word store in the upper half of a line
    ref_store(32'h0000_0104, 4, 64'h1234_5678_DEAD_BEEF);
    issue(1'b1, 32'h0000_0104, 2'd2, 1'b0, 64'h1234_5678_DEAD_BEEF, acc, ok, rdy);
    vectors++; if (!ok || s_q.size() != 1) begin miscompares++; $display("FAIL w104_strobes: got ok=%b n=%0d want 1/1", ok, s_q.size()); end
    vectors++; if ({s_q[0].wr, s_q[0].addr, s_q[0].be} !== {1'b1, 32'h0000_0100, 8'hF0}) begin miscompares++; $display("FAIL w104_lo: got wr=%b addr=%h be=%h want 1/00000100/f0", s_q[0].wr, s_q[0].addr, s_q[0].be); end
    vectors++; if (s_q[0].wd !== 64'hDEAD_BEEF_0000_0000) begin miscompares++; $display("FAIL w104_wdata: got %h want deadbeef00000000", s_q[0].wd); end
    vectors++; if (rsp_c_q[0] != acc + 2 || rdy !== 1'b1) begin miscompares++; $display("FAIL w104_lat: got rsp=T+%0d ready=%b want T+2/1", rsp_c_q[0] - acc, rdy); end
    // Doubleword store crossing into the next line
    ref_store(32'h0000_010B, 8, 64'h1122_3344_5566_7788);
    issue(1'b1, 32'h0000_010B, 2'd3, 1'b0, 64'h1122_3344_5566_7788, acc, ok, rdy);
    vectors++; if (!ok || s_q.size() != 2) begin miscompares++; $display("FAIL dw10b_strobes: got ok=%b n=%0d want 1/2", ok, s_q.size()); end
    vectors++; if ({s_q[0].addr, s_q[0].be, s_q[0].wd} !== {32'h0000_0108, 8'hF8, 64'h4455_6677_8800_0000}) begin miscompares++; $display("FAIL dw10b_lo: got addr=%h be=%h wd=%h want 00000108/f8/4455667788000000", s_q[0].addr, s_q[0].be, s_q[0].wd); end
    vectors++; if ({s_q[1].addr, s_q[1].be, s_q[1].wd} !== {32'h0000_0110, 8'h07, 64'h0000_0000_0011_2233}) begin miscompares++; $display("FAIL dw10b_hi: got addr=%h be=%h wd=%h want 00000110/07/0000000000112233", s_q[1].addr, s_q[1].be, s_q[1].wd); end
    vectors++; if (rsp_c_q[0] != acc + 3) begin miscompares++; $display("FAIL dw10b_lat: got T+%0d want T+3", rsp_c_q[0] - acc); end
    // Crossing halfword load: prepare LO byte7 = 0x80, HI byte0 = 0xFF
    ref_store(32'h0000_0207, 1, 64'h80);
    issue(1'b1, 32'h0000_0207, 2'd0, 1'b0, 64'h80, acc, ok, rdy);
    ref_store(32'h0000_0208, 1, 64'hFF);
    issue(1'b1, 32'h0000_0208, 2'd0, 1'b0, 64'hFF, acc, ok, rdy);
    issue(1'b0, 32'h0000_0207, 2'd1, 1'b0, {$urandom, $urandom}, acc, ok, rdy);
    vectors++; if (!ok || rsp_d_q[0] !== 64'hFFFF_FFFF_FFFF_FF80) begin miscompares++; $display("FAIL hw207_signed: got ok=%b d=%h want ffffffffffffff80", ok, rsp_d_q[0]); end
    vectors++; if (rsp_c_q[0] != acc + 3) begin miscompares++; $display("FAIL hw207_lat: got T+%0d want T+3", rsp_c_q[0] - acc); end
    issue(1'b0, 32'h0000_0207, 2'd1, 1'b1, {$urandom, $urandom}, acc, ok, rdy);
    vectors++; if (!ok || rsp_d_q[0] !== 64'h0000_0000_0000_FF80) begin miscompares++; $display("FAIL hw207_unsigned: got ok=%b d=%h want 000000000000ff80", ok, rsp_d_q[0]); end
    // Word store wrapping past the top of the address space
    ref_store(32'hFFFF_FFFE, 4, 64'hCAFE_F00D);
    issue(1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0, 64'hCAFE_F00D, acc, ok, rdy);
    vectors++; if (!ok || s_q.size() != 2) begin miscompares++; $display("FAIL wtop_strobes: got ok=%b n=%0d want 1/2", ok, s_q.size()); end
    vectors++; if ({s_q[0].addr, s_q[0].be, s_q[1].addr, s_q[1].be} !== {32'hFFFF_FFF8, 8'hC0, 32'h0000_0000, 8'h03}) begin miscompares++; $display("FAIL wtop_lines: got %h/%h %h/%h want fffffff8/c0 00000000/03", s_q[0].addr, s_q[0].be, s_q[1].addr, s_q[1].be); end
  endtask

  task automatic test_random();
    int acc, cnt, n; bit ok; logic rdy;
    logic wr, uns; logic [1:0] unit; logic [31:0] addr, base; logic [63:0] wd, exp_rd;
    logic [1:0][31:0] la; logic [1:0][7:0] be; logic [1:0][63:0] wdv;
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 2))
        0: base = 32'h0000_1000;
        1: base = 32'hFFFF_FFC0;
        default: base = 32'h8000_0000;
      endcase
      addr = base + 32'($urandom_range(0, 63));
      wr = 1'($urandom); uns = 1'($urandom); unit = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      n = 1 << unit;
      model_strobes(addr, n, wd, cnt, la, be, wdv);
      exp_rd = wr ? 64'd0 : ref_load(addr, n, uns);
      if (wr) ref_store(addr, n, wd);
      issue(wr, addr, unit, uns, wd, acc, ok, rdy);
      vectors++; if (!ok || s_q.size() != cnt) begin miscompares++; $display("FAIL rnd%0d_strobes: addr=%h n=%0d got ok=%b strobes=%0d want 1/%0d", t, addr, n, ok, s_q.size(), cnt); end
      for (int i = 0; i < cnt && i < s_q.size(); i++) begin
        vectors++;
        if ({s_q[i].wr, s_q[i].addr, s_q[i].be, s_q[i].wd} !== {wr, la[i], be[i], wdv[i]} || s_q[i].c != acc + 1 + i) begin
          miscompares++;
          $display("FAIL rnd%0d_line%0d: got wr=%b addr=%h be=%h wd=%h at T+%0d want %b/%h/%h/%h at T+%0d",
                   t, i, s_q[i].wr, s_q[i].addr, s_q[i].be, s_q[i].wd, s_q[i].c - acc, wr, la[i], be[i], wdv[i], 1 + i);
        end
      end
      vectors++; if (rsp_c_q.size() != 1 || rsp_c_q[0] != acc + 1 + cnt || rdy !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_rsp: got count=%0d at T+%0d ready=%b want 1 at T+%0d ready=1", t, rsp_c_q.size(), rsp_c_q[0] - acc, rdy, 1 + cnt); end
      vectors++; if (rsp_d_q[0] !== exp_rd) begin miscompares++; $display("FAIL rnd%0d_rdata: wr=%b addr=%h n=%0d uns=%b got %h want %h", t, wr, addr, n, uns, rsp_d_q[0], exp_rd); end
    end
  endtask

  task automatic test_reset_abort();
    int acc; bit ok; logic rdy; logic [63:0] d, exp_rd;
    d = {$urandom, $urandom};
    @(negedge clk);
    vectors++; if (o_req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got ready=%b want 1", o_req_ready); end
    i_req_wr = 1'b1; i_req_addr = 32'h0000_3004; i_req_unit = 2'd3;
    i_req_unsigned = 1'b0; i_req_wdata = d; i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    clear_queues();
    @(posedge clk);
    #1;
    vectors++; if (o_dm_en !== 1'b1 || o_dm_addr !== 32'h0000_3008) begin miscompares++; $display("FAIL abort_in_hi: got en=%b addr=%h want 1/00003008", o_dm_en, o_dm_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({o_dm_en, o_dm_wr, o_dm_be, o_dm_addr, o_dm_wdata} !== 106'd0) begin miscompares++; $display("FAIL abort_dm_zero: got en=%b wr=%b be=%h addr=%h wd=%h want 0", o_dm_en, o_dm_wr, o_dm_be, o_dm_addr, o_dm_wdata); end
    vectors++; if ({o_busy, o_req_ready, o_rsp_valid} !== 3'b010) begin miscompares++; $display("FAIL abort_ctl: got busy=%b ready=%b rsp=%b want 0/1/0", o_busy, o_req_ready, o_rsp_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (rsp_c_q.size() != 0 || s_q.size() != 1) begin miscompares++; $display("FAIL abort_no_rsp: got rsps=%0d strobes=%0d want 0/1", rsp_c_q.size(), s_q.size()); end
    // Only the LO half (bytes at 0x3004..0x3007) reached memory
    ref_store(32'h0000_3004, 4, d);
    exp_rd = ref_load(32'h0000_3004, 8, 1'b1);
    issue(1'b0, 32'h0000_3004, 2'd3, 1'b1, 64'd0, acc, ok, rdy);
    vectors++; if (!ok || rsp_c_q[0] != acc + 3 || rsp_d_q[0] !== exp_rd) begin miscompares++; $display("FAIL abort_next: got ok=%b T+%0d d=%h want T+3 d=%h", ok, rsp_c_q[0] - acc, rsp_d_q[0], exp_rd); end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b; logic [63:0] exp_a;
    exp_a = ref_load(32'h0000_1006, 4, 1'b0);
    ref_store(32'h0000_1010, 1, 64'h5A);
    acc_b = -1;
    @(negedge clk);
    i_req_wr = 1'b0; i_req_addr = 32'h0000_1006; i_req_unit = 2'd2;
    i_req_unsigned = 1'b0; i_req_wdata = 64'd0; i_req_valid = 1'b1;
    acc_a = cyc;
    @(posedge clk);
    #1;
    clear_queues();
    i_req_wr = 1'b1; i_req_addr = 32'h0000_1010; i_req_unit = 2'd0; i_req_wdata = 64'h5A;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_req_ready) begin
        acc_b = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    vectors++; if (acc_b != acc_a + 4) begin miscompares++; $display("FAIL b2b_accept: got T+%0d want T+4", acc_b - acc_a); end
    vectors++; if (rsp_c_q.size() != 2 || rsp_c_q[0] != acc_a + 3 || rsp_c_q[1] != acc_a + 6) begin miscompares++; $display("FAIL b2b_rsp: got n=%0d at T+%0d,T+%0d want 2 at T+3,T+6", rsp_c_q.size(), rsp_c_q[0] - acc_a, rsp_c_q[1] - acc_a); end
    vectors++; if (rsp_d_q[0] !== exp_a || rsp_d_q[1] !== 64'd0) begin miscompares++; $display("FAIL b2b_rdata: got %h/%h want %h/0", rsp_d_q[0], rsp_d_q[1], exp_a); end
    vectors++; if (s_q.size() != 3 || {s_q[2].wr, s_q[2].addr, s_q[2].be, s_q[2].wd} !== {1'b1, 32'h0000_1010, 8'h01, 64'h5A} || s_q[2].c != acc_a + 5) begin miscompares++; $display("FAIL b2b_second: got n=%0d addr=%h be=%h wd=%h at T+%0d want 3 00001010/01/5a at T+5", s_q.size(), s_q[2].addr, s_q[2].be, s_q[2].wd, s_q[2].c - acc_a); end
  endtask

  initial begin
    i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = 32'd0;
    i_req_unit = 2'd0; i_req_unsigned = 1'b0; i_req_wdata = 64'd0;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
